spi_sck_gen: RTL
================

SPI_SCK_GEN -- requirements
Module: spi_sck_gen

Interface
REQ-001 SHALL have parameter NBITS, default 8, meaning bits per transfer (SCK edge count = 2*NBITS).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port SPE  input  1  SPI enable; low forces idle/abort.
REQ-005 SHALL have port SPIBR  input  8  baud-rate register: SPPR=[6:4], SPR=[2:0], bits 7 and 3 ignored.
REQ-006 SHALL have port CPOL  input  1  SCK idle level.
REQ-007 SHALL have port CPHA  input  1  clock phase select.
REQ-008 SHALL have port start  input  1  single-cycle transfer request.
REQ-009 SHALL have port SCK  output  1  registered serial clock to the SPI shifter/pin.
REQ-010 SHALL have port sample_en  output  1  one-cycle strobe: shifter captures MISO.
REQ-011 SHALL have port shift_en  output  1  one-cycle strobe: shifter drives next MOSI bit.
REQ-012 SHALL have port busy  output  1  transfer in progress.
REQ-013 SHALL have port done  output  1  one-cycle transfer-complete strobe.

Function
REQ-014 Half-period H SHALL be (SPPR+1) << SPR system clocks; range 1..1024, counter at least 11 bits, no overflow.
REQ-015 Idle: SCK SHALL equal CPOL one cycle after CPOL changes; sample_en, shift_en, done SHALL be 0.
REQ-016 start=1 with busy=0 and SPE=1 SHALL latch SPIBR, CPOL, CPHA and set busy=1 on the next cycle (cycle B).
REQ-017 start while busy=1 or SPE=0 SHALL be ignored; SPIBR/CPOL/CPHA changes during a transfer SHALL have no effect.
REQ-018 Edge k (k=1..2*NBITS) SHALL be the cycle B+k*H in which SCK first shows its toggled level.
REQ-019 CPHA=0: odd edges SHALL pulse sample_en; even edges 2..2*NBITS-2 SHALL pulse shift_en; edge 2*NBITS pulses neither.
REQ-020 CPHA=1: odd edges SHALL pulse shift_en; even edges SHALL pulse sample_en.
REQ-021 Strobes SHALL be coincident with the SCK change cycle and never both high in one cycle.
REQ-022 At cycle B+(2*NBITS+1)*H done SHALL be 1 for one cycle and busy SHALL be 0 in that same cycle.
REQ-023 start in the done cycle SHALL be accepted (back-to-back), giving busy low for exactly one cycle.
REQ-024 SPE=0 while busy SHALL abort: next cycle busy=0, SCK=latched CPOL, counters cleared, no done, no further strobes.
REQ-025 States SHALL be IDLE, RUN (count H, emit edge), TAIL (final half-period before done); IDLE->RUN on accepted start, RUN->TAIL after edge 2*NBITS, TAIL->IDLE with done; any state->IDLE on SPE=0.

Reset
REQ-026 nRST low SHALL immediately force state=IDLE, SCK=0, busy=0, done=0, sample_en=0, shift_en=0, counters=0, latched fields=0.
REQ-027 After nRST release SCK SHALL follow CPOL per REQ-015; assertion mid-transfer SHALL abandon it with no done.

Structure
REQ-028 Package spi_pkg SHALL hold SPIBR field positions (SPPR, SPR), state encoding, half-period counter width (11) and default NBITS.
REQ-029 Sub-module spi_half_period_timer SHALL compute H, count it and emit a one-cycle tick; spi_sck_gen holds FSM, edge counter, SCK and strobes.

Verification
REQ-030 SPIBR=0x00, CPOL=0, CPHA=0, start: H=1, SCK toggles every cycle B+1..B+16, 8 sample_en on rising edges, 7 shift_en, done at B+17.
REQ-031 SPIBR=0x21 (SPPR=2, SPR=1): H=6, first SCK rise at B+6, done at B+102; SPIBR changed to 0x00 at B+10 has no effect.
REQ-032 SPIBR=0x00, CPOL=1, CPHA=1: idle SCK=1, shift_en on falling edges 1,3..15, sample_en on rising edges 2..16, done at B+17.
REQ-033 SPIBR=0x77: H=1024, done at B+17408, exactly 16 SCK toggles.
REQ-034 SPE=0 at edge 5 -> next cycle busy=0, SCK=CPOL, no done; nRST low mid-transfer -> SCK=0, busy=0 immediately.
REQ-035 start held during busy ignored; start in done cycle -> busy=0 one cycle, then new transfer with identical edge timing.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPIBR field positions, FSM encoding and half-period helper for the SPI clock generator.
package spi_pkg;
  localparam int SPPR_MSB  = 6;
  localparam int SPPR_LSB  = 4;
  localparam int SPR_MSB   = 2;
  localparam int SPR_LSB   = 0;
  localparam int HP_W      = 11;
  localparam int NBITS_DEF = 8;

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_e;

  typedef struct packed {
    logic [2:0] sppr;
    logic [2:0] spr;
    logic       cpol;
    logic       cpha;
  } cfg_t;

  // (SPPR+1) << SPR tops out at 1024, which fits HP_W bits
  function automatic logic [HP_W-1:0] half_period(input logic [2:0] sppr, input logic [2:0] spr);
    return (HP_W'(sppr) + HP_W'(1)) << spr;
  endfunction
endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer: counts one SCK half-period and pulses tick_o in its last system clock.
module spi_half_period_timer
  import spi_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       en_i,
  input  logic [2:0] sppr_i,
  input  logic [2:0] spr_i,
  output logic       tick_o
);
  logic [HP_W-1:0] cnt_q, cnt_d, hp;

  assign hp     = half_period(sppr_i, spr_i);
  assign tick_o = en_i && (cnt_q == hp - HP_W'(1));
  assign cnt_d  = (en_i && !tick_o) ? cnt_q + HP_W'(1) : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SPI master serial-clock generator with CPOL/CPHA-aware sample/shift strobes.
// Registered SCK and strobes change together in the cycle each edge becomes visible.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       SPE,
  input  logic [7:0] SPIBR,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic       start,
  output logic       SCK,
  output logic       sample_en,
  output logic       shift_en,
  output logic       busy,
  output logic       done
);
  localparam int EW = $clog2(2*NBITS+1);
  localparam logic [EW-1:0] LAST_M1 = EW'(2*NBITS-1);

  state_e        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [EW-1:0] edge_q, edge_d;
  logic          sck_q, sck_d, smp_q, smp_d, shf_q, shf_d, done_q, done_d;
  logic          tick, fire, k_odd;

  spi_half_period_timer u_timer (
    .CLK    (CLK),
    .nRST   (nRST),
    .en_i   (SPE && state_q != IDLE),
    .sppr_i (cfg_q.sppr),
    .spr_i  (cfg_q.spr),
    .tick_o (tick)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      edge_q  <= '0;
      sck_q   <= 1'b0;
      smp_q   <= 1'b0;
      shf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      edge_q  <= edge_d;
      sck_q   <= sck_d;
      smp_q   <= smp_d;
      shf_q   <= shf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    edge_d  = edge_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cfg_d   = '{SPIBR[SPPR_MSB:SPPR_LSB], SPIBR[SPR_MSB:SPR_LSB], CPOL, CPHA};
      end
      RUN: if (tick) begin
        edge_d  = edge_q + EW'(1);
        state_d = (edge_q == LAST_M1) ? TAIL : RUN;
      end
      TAIL: if (tick) begin
        edge_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!SPE) begin
      state_d = IDLE;
      edge_d  = '0;
    end
  end

  // edge_q counts edges already emitted, so the edge being emitted is odd when edge_q is even
  always_comb begin
    k_odd  = !edge_q[0];
    fire   = SPE && tick && state_q == RUN;
    sck_d  = (state_q == IDLE) ? CPOL : !SPE ? cfg_q.cpol : fire ? !sck_q : sck_q;
    smp_d  = fire && (cfg_q.cpha ? !k_odd : k_odd);
    shf_d  = fire && (cfg_q.cpha ? k_odd : (!k_odd && edge_q != LAST_M1));
    done_d = SPE && tick && state_q == TAIL;
  end

  assign SCK       = sck_q;
  assign sample_en = smp_q;
  assign shift_en  = shf_q;
  assign done      = done_q;
  assign busy      = state_q != IDLE;
endmodule
